// File: rtl/uart_arb_pkg.sv
// Shared constants and types for the UART transmitter arbiter.
// Holds the state encoding, the watchdog/gap counter width and the grant index width.
package uart_arb_pkg;

    localparam int CNT_W = 16;
    localparam int GID_W = 3;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [GID_W-1:0] gid_t;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOAD      = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_GAP       = 2'd3;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: the first set request after last_grant wins,
// and the search wraps around.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  gid_t               last_grant,
    output logic               valid,
    output gid_t               winner
);

    logic [NUM_REQ-1:0] w_rot;
    gid_t               w_offset;
    logic [4:0]         w_sum;

    // Rotate the doubled vector so that bit 0 is the requester right after last_grant.
    assign w_rot = NUM_REQ'({req, req} >> ({1'b0, last_grant} + 4'd1));

    always_comb begin
        valid    = 1'b0;
        w_offset = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                valid    = 1'b1;
                w_offset = GID_W'(j);
            end
        end
    end

    always_comb begin
        w_sum = {2'b00, last_grant} + {2'b00, w_offset} + 5'd1;
        if (w_sum >= 5'(NUM_REQ)) begin
            w_sum = w_sum - 5'(NUM_REQ);
        end
    end

    assign winner = GID_W'(w_sum);

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters,
// with a tx_done watchdog and a fixed idle gap between transfers.
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GAP_CYC = 16,
    parameter int TIMEOUT = 65535,
    parameter int DLY     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_done,
    output logic                 busy,
    output logic [GID_W-1:0]     grant_id,
    output logic                 timeout
);

    localparam cnt_t       TIMEOUT_C     = CNT_W'(TIMEOUT);
    localparam cnt_t       GAP_LAST      = CNT_W'(GAP_CYC - 1);
    localparam logic [1:0] ST_AFTER_DONE = (GAP_CYC == 0) ? ST_LOAD : ST_GAP;

    // DLY is kept for drop-in compatibility; this implementation models no delay.
    if (DLY < 0) begin : g_dly_unused
    end

    logic [1:0]         r_state;
    cnt_t               r_cnt;
    logic [NUM_REQ-1:0] r_ack;
    logic [7:0]         r_tx_data;
    logic               r_tx_start;
    logic               r_timeout;
    gid_t               r_grant_id;
    gid_t               r_last_grant;

    logic               w_valid;
    gid_t               w_winner;
    logic [NUM_REQ-1:0] w_hit;
    logic [7:0]         w_byte;
    cnt_t               w_cnt_inc;

    uart_rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req       (req),
        .last_grant(r_last_grant),
        .valid     (w_valid),
        .winner    (w_winner)
    );

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_hit
        assign w_hit[gi] = (w_winner == GID_W'(gi));
    end

    always_comb begin
        w_byte = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_hit[i]) begin
                w_byte = req_data[8*i +: 8];
            end
        end
    end

    assign w_cnt_inc = r_cnt + cnt_t'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_ack        <= '0;
            r_tx_data    <= 8'h00;
            r_tx_start   <= 1'b0;
            r_timeout    <= 1'b0;
            r_grant_id   <= '0;
            r_last_grant <= GID_W'(NUM_REQ - 1);
        end else begin
            r_ack      <= '0;
            r_tx_start <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                ST_IDLE, ST_LOAD: begin
                    if (w_valid) begin
                        r_tx_data    <= w_byte;
                        r_ack        <= w_hit;
                        r_tx_start   <= 1'b1;
                        r_grant_id   <= w_winner;
                        r_last_grant <= w_winner;
                        r_cnt        <= '0;
                        r_state      <= ST_WAIT_DONE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT_DONE: begin
                    // A completion arriving on the expiry cycle wins over the watchdog.
                    if (tx_done) begin
                        r_cnt   <= '0;
                        r_state <= ST_AFTER_DONE;
                    end else if (w_cnt_inc == TIMEOUT_C) begin
                        r_cnt     <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack      = r_ack;
    assign tx_data  = r_tx_data;
    assign tx_start = r_tx_start;
    assign timeout  = r_timeout;
    assign grant_id = r_grant_id;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: a round-robin model queues expected grants
// when requests are driven, and a monitor pops and compares them at each tx_start.
module tb_uart_tx_arb;

    localparam int NREQ = 4;
    localparam int GAPC = 16;
    localparam int TMO  = 100;

    typedef struct {
        logic [2:0] id;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic        busy;
    logic [2:0]  grant_id;
    logic        timeout;

    exp_t sb_q[$];
    exp_t e_cur;
    int   n_vec     = 0;
    int   n_miss    = 0;
    int   n_timeout = 0;
    int   cyc       = 0;
    int   m_last    = NREQ - 1;
    int   t0, t_done, t_start;
    bit   seen;
    logic prev_start = 1'b0;

    uart_tx_arb #(
        .NUM_REQ(NREQ),
        .GAP_CYC(GAPC),
        .TIMEOUT(TMO),
        .DLY    (0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_data(req_data),
        .ack     (ack),
        .tx_data (tx_data),
        .tx_start(tx_start),
        .tx_done (tx_done),
        .busy    (busy),
        .grant_id(grant_id),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference round-robin: expected grant order for pattern r, dropping acked bits unless held.
    task automatic push_seq(input logic [3:0] r, input int n, input bit hold);
        int w;
        int idx;
        for (int t = 0; t < n; t++) begin
            w = -1;
            for (int k = 1; k <= NREQ && w < 0; k++) begin
                idx = (m_last + k) % NREQ;
                if (((r >> idx) & 4'b0001) != 4'b0000) w = idx;
            end
            if (w >= 0) begin
                sb_q.push_back('{id: 3'(w), data: 8'(req_data >> (8 * w))});
                m_last = w;
                if (!hold) r = r & ~(4'b0001 << w);
            end
        end
    endtask

    task automatic wait_start(input int budget);
        bit got_it = 1'b0;
        for (int i = 0; i < budget && !got_it; i++) begin
            @(negedge clk);
            got_it = tx_start;
        end
        if (!got_it) check("start_wait_expired", 32'(tx_start), 32'd1);
    endtask

    task automatic finish_xfer(input int after, input bit drop);
        if (drop) req = req & ~ack;
        repeat (after) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic serve(input int n, input bit hold, input int after);
        for (int t = 0; t < n; t++) begin
            wait_start(60);
            finish_xfer(after, !hold);
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) @(negedge clk);
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_start) begin
                $display("[%0d] tx_start grant_id=%0d tx_data=%02h ack=%b", cyc, grant_id, tx_data, ack);
                if (sb_q.size() == 0) begin
                    check("unexpected_start", 32'(tx_start), 32'd0);
                end else begin
                    e_cur = sb_q.pop_front();
                    check("tx_data", 32'(tx_data), 32'(e_cur.data));
                    check("grant_id", 32'(grant_id), 32'(e_cur.id));
                    check("ack", 32'(ack), 32'(4'b0001 << e_cur.id));
                end
                if (prev_start) check("start_width", 32'(prev_start), 32'd0);
            end else if (ack != 4'b0000) begin
                check("ack_without_start", 32'(ack), 32'd0);
            end
            if (timeout) n_timeout++;
        end
        prev_start <= tx_start && !rst;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got still running at cycle %0d, want finished", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 1'b1; req = '0; req_data = '0; tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;

        // All four held high: grants rotate 0,1,2,3,0,1,2,3.
        req_data = 32'h4433_2211; req = 4'b1111;
        push_seq(4'b1111, 8, 1'b1);
        serve(8, 1'b1, 3);
        req = '0;
        wait_idle(40);

        // Two requesters that drop on ack.
        req_data = 32'h003C_00A5; req = 4'b0101;
        push_seq(4'b0101, 2, 1'b0);
        serve(2, 1'b0, 4);
        wait_idle(40);

        // Grant latency, gap length, and tx_done / req changes ignored during GAP.
        req_data = 32'hD4C3_B2A1;
        req = 4'b0010; t0 = cyc;
        push_seq(4'b0010, 1, 1'b0);
        wait_start(10);
        check("start_latency", 32'(cyc - t0), 32'd1);
        req = 4'b1000;
        push_seq(4'b1000, 1, 1'b0);
        repeat (2) @(negedge clk);
        tx_done = 1'b1; t_done = cyc;
        @(negedge clk);
        tx_done = 1'b0;
        repeat (4) @(negedge clk);
        check("gap_busy", 32'(busy), 32'd1);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        req = 4'b1100;
        repeat (2) @(negedge clk);
        req = 4'b1000;
        wait_start(40);
        check("gap_length", 32'(cyc - t_done), 32'(GAPC + 2));
        finish_xfer(2, 1'b1);
        wait_idle(40);

        // tx_done while idle changes nothing.
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_done_busy", 32'(busy), 32'd0);

        // Watchdog: tx_done withheld.
        req_data = 32'h005A_00E7; req = 4'b0100;
        push_seq(4'b0100, 1, 1'b0);
        wait_start(10);
        t_start = cyc;
        req = req & ~ack;
        seen = 1'b0;
        for (int i = 0; i < 150 && !seen; i++) begin
            @(negedge clk);
            seen = timeout;
        end
        check("timeout_cycle", 32'(cyc - t_start), 32'(TMO));
        check("timeout_busy", 32'(busy), 32'd0);
        req = 4'b0001;
        push_seq(4'b0001, 1, 1'b0);
        serve(1, 1'b0, 2);
        wait_idle(40);

        // Reset in the middle of WAIT_DONE, then requester 3 alone.
        req_data = 32'h9F00_6600; req = 4'b0010;
        push_seq(4'b0010, 1, 1'b0);
        wait_start(10);
        req = req & ~ack;
        repeat (3) @(negedge clk);
        rst = 1'b1; m_last = NREQ - 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_grant_id", 32'(grant_id), 32'd0);
        check("rst_mid_tx_data", 32'(tx_data), 32'd0);
        repeat (6) @(negedge clk);
        req = 4'b1000;
        push_seq(4'b1000, 1, 1'b0);
        serve(1, 1'b0, 2);
        wait_idle(40);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        check("timeout_pulses", 32'(n_timeout), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter GAP_CYC, 16, idle clk cycles inserted after each tx_done before next grant (0 allowed).
REQ-003 Parameter TIMEOUT, 65535, max clk cycles waited for tx_done before abort (16-bit counter).
REQ-004 Parameter DLY, 0, simulation delay applied on every registered assignment.
REQ-005 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 req  input  NUM_REQ  per-requester level request; held high with data stable until ack.
REQ-008 req_data  input  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
REQ-009 ack  output  NUM_REQ  one-cycle pulse to the granted requester when its byte is latched.
REQ-010 tx_data  output  8  latched byte to transmitter.
REQ-011 tx_start  output  1  one-cycle start pulse to transmitter.
REQ-012 tx_done  input  1  one-cycle completion pulse from transmitter.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 grant_id  output  3  index of current/last granted requester.
REQ-015 timeout  output  1  one-cycle pulse on transmitter watchdog expiry.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, WAIT_DONE, GAP.
REQ-017 IDLE: when any req bit is high, select winner round-robin, latch req_data[winner] into tx_data, pulse ack[winner] and tx_start in the same cycle, set grant_id, go WAIT_DONE.
REQ-018 LOAD is a reserved single-cycle state entered only from GAP when GAP_CYC=0 path requires re-arbitration; it behaves identically to IDLE arbitration and SHALL never last more than one cycle.
REQ-019 Round-robin: search starts at (last_grant+1) mod NUM_REQ, wraps, first set req bit wins; last_grant updates only on a grant.
REQ-020 Latency: req high in IDLE -> tx_start and ack on the next rising edge (1 cycle).
REQ-021 WAIT_DONE: watchdog counter increments each cycle; tx_done -> go GAP (or LOAD if GAP_CYC=0), counter cleared.
REQ-022 WAIT_DONE: counter reaching TIMEOUT without tx_done -> pulse timeout, go IDLE, counter cleared; tx_done on the same cycle as expiry takes priority (no timeout pulse).
REQ-023 GAP: count GAP_CYC cycles, then go IDLE; req changes during GAP SHALL be ignored.
REQ-024 tx_done received in IDLE, LOAD or GAP SHALL be ignored.
REQ-025 Requests dropped before ack SHALL never be granted; a requester whose req stays high is served again only after all other active requesters.
REQ-026 ack and tx_start SHALL never be high for more than one consecutive cycle; at most one ack bit high.

Reset
REQ-027 On rst: state IDLE, ack=0, tx_start=0, tx_data=8'h00, busy=0, timeout=0, grant_id=0, last_grant=NUM_REQ-1 (requester 0 wins first), counters 0.
REQ-028 rst asserted mid-transfer SHALL abort immediately with no ack/tx_start pulse on release; first grant after release follows REQ-027 priority.

Structure
REQ-029 State encoding, counter width (16) and grant_id width (3) SHALL live in shared package uart_arb_pkg.
REQ-030 Round-robin selection SHALL be a combinational sub-module uart_rr_pick (inputs req, last_grant; outputs valid, winner index).

Verification
REQ-031 After reset, req=4'b0101, data0=8'hA5, data2=8'h3C -> first tx_start with tx_data=8'hA5, ack=4'b0001; after tx_done+GAP, tx_start with 8'h3C, ack=4'b0100.
REQ-032 req=4'b1111 held for 8 grants -> grant_id sequence 0,1,2,3,0,1,2,3.
REQ-033 Single req at IDLE -> tx_start exactly 1 cycle later; tx_done then exactly GAP_CYC=16 idle cycles before next tx_start.
REQ-034 TIMEOUT=100, tx_done withheld -> timeout pulse at cycle 100 after tx_start, busy falls, next req granted normally.
REQ-035 rst pulsed during WAIT_DONE, then req=4'b1000 -> no stray pulses; grant_id=3 granted with ack=4'b1000.
REQ-036 tx_done pulsed in IDLE and GAP -> no state change, no ack/tx_start.
